// File: rtl/fp_regfile_pkg.sv
// rtl/fp_regfile_pkg.sv - shared types and FP field constants for fp_regfile_mp
package fp_regfile_pkg;

  typedef enum logic {CLEAR, READY} state_t;

  localparam int EXP_W = 8;
  localparam int MAN_W = 23;
  localparam logic [EXP_W-1:0] EXP_MAX = 8'hFF;

  localparam int CLS_NAN    = 3;
  localparam int CLS_INF    = 2;
  localparam int CLS_ZERO   = 1;
  localparam int CLS_DENORM = 0;

endpackage

// File: rtl/fp_classify.sv
// rtl/fp_classify.sv - combinational IEEE-754 single-precision class decode
module fp_classify
  import fp_regfile_pkg::*;
(
  input  logic [31:0] data,
  output logic [3:0]  cls
);

  logic [EXP_W-1:0] exp_f;
  logic [MAN_W-1:0] man_f;
  logic             unused_sign;

  assign exp_f       = data[30:23];
  assign man_f       = data[22:0];
  assign unused_sign = data[31];

  // Decode exponent/mantissa into one-hot {nan,inf,zero,denorm}; normals give 0
  always_comb begin
    cls             = '0;
    cls[CLS_NAN]    = (exp_f == EXP_MAX) && (man_f != '0);
    cls[CLS_INF]    = (exp_f == EXP_MAX) && (man_f == '0);
    cls[CLS_ZERO]   = (exp_f == '0) && (man_f == '0);
    cls[CLS_DENORM] = (exp_f == '0) && (man_f != '0);
  end

endmodule

// File: rtl/fp_regfile_mp.sv
// rtl/fp_regfile_mp.sv - multi-read-port register file with self-clear; FP_CLASSIFY_EN adds rd_class
module fp_regfile_mp
  import fp_regfile_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 32,
  parameter int ADDR_W = $clog2(DEPTH),
  parameter int NUM_RD = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr_req,
  output logic                     busy,
  output logic                     req_drop,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic [NUM_RD-1:0]        rd_en,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_valid
`ifdef FP_CLASSIFY_EN
  ,
  output logic [NUM_RD*4-1:0]      rd_class
`endif
);

  // Extra top bit lets out-of-range addresses compare correctly for non-power-of-2 depths
  localparam logic [ADDR_W:0]   DEPTH_L  = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

  state_t            state;
  logic [ADDR_W-1:0] clr_idx;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rd_next [NUM_RD];
  logic              wr_ok;

  assign wr_ok = (state == READY) && wr_en && ({1'b0, wr_addr} < DEPTH_L);

  // Clear sequencer: walks every entry once after reset or clr_req, blocking access meanwhile
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= CLEAR;
      clr_idx  <= '0;
      busy     <= 1'b1;
      req_drop <= 1'b0;
    end else begin
      req_drop <= (state == CLEAR) && (wr_en || (|rd_en));
      case (state)
        CLEAR: begin
          if (clr_idx == LAST_IDX) begin
            state   <= READY;
            busy    <= 1'b0;
            clr_idx <= '0;
          end else begin
            clr_idx <= clr_idx + 1'b1;
          end
        end
        READY: begin
          if (clr_req) begin
            state   <= CLEAR;
            busy    <= 1'b1;
            clr_idx <= '0;
          end
        end
        default: state <= CLEAR;
      endcase
    end
  end

  // Storage: clear sequencer owns the write port while clearing
  always_ff @(posedge clk) begin
    if (!rst && state == CLEAR) begin
      mem[clr_idx] <= '0;
    end else if (!rst && wr_ok) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Per-port next read word: write-first bypass, zero for out-of-range addresses
  always_comb begin
    for (int i = 0; i < NUM_RD; i++) begin
      rd_next[i] = '0;
      if ({1'b0, rd_addr[i*ADDR_W +: ADDR_W]} < DEPTH_L) begin
        if (wr_ok && (wr_addr == rd_addr[i*ADDR_W +: ADDR_W])) begin
          rd_next[i] = wr_data;
        end else begin
          rd_next[i] = mem[rd_addr[i*ADDR_W +: ADDR_W]];
        end
      end
    end
  end

`ifdef FP_CLASSIFY_EN
  logic [3:0] cls_next [NUM_RD];

  if (DATA_W != 32) begin : g_bad_width
    $error("fp_regfile_mp: FP_CLASSIFY_EN requires DATA_W == 32");
  end

  for (genvar g = 0; g < NUM_RD; g++) begin : g_cls
    fp_classify u_cls (
      .data (rd_next[g][31:0]),
      .cls  (cls_next[g])
    );
  end
`endif

  // Read registers: data and class update only on an accepted request, valid pulses once
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data  <= '0;
      rd_valid <= '0;
`ifdef FP_CLASSIFY_EN
      rd_class <= '0;
`endif
    end else begin
      for (int i = 0; i < NUM_RD; i++) begin
        rd_valid[i] <= (state == READY) && rd_en[i];
        if ((state == READY) && rd_en[i]) begin
          rd_data[i*DATA_W +: DATA_W] <= rd_next[i];
`ifdef FP_CLASSIFY_EN
          rd_class[i*4 +: 4] <= cls_next[i];
`endif
        end
      end
    end
  end

endmodule

// File: tb/tb_fp_regfile_mp.sv
// tb/tb_fp_regfile_mp.sv - self-checking bench for fp_regfile_mp (DEPTH 32 and DEPTH 20 instances)
module tb_fp_regfile_mp;

  logic        clk = 1'b0;
  logic        rst;
  logic        clr_req, wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic [1:0]  rd_en;
  logic [9:0]  rd_addr;
  logic        busy, req_drop;
  logic [63:0] rd_data;
  logic [1:0]  rd_valid;

  logic        b_clr_req, b_wr_en;
  logic [4:0]  b_wr_addr;
  logic [31:0] b_wr_data;
  logic [1:0]  b_rd_en;
  logic [9:0]  b_rd_addr;
  logic        b_busy, b_req_drop;
  logic [63:0] b_rd_data;
  logic [1:0]  b_rd_valid;
`ifdef FP_CLASSIFY_EN
  logic [7:0]  rd_class;
  logic [7:0]  b_rd_class;
`endif

  int          pass_cnt = 0;
  int          total_cnt = 0;
  int          cnt;
  logic [31:0] model_a [32];
  logic [31:0] model_b [20];
  logic [31:0] q0 [$];
  logic [31:0] q1 [$];
  logic [31:0] got;
  logic [31:0] want;
  logic [1:0]  exp_v;

  always #5 clk = ~clk;

  fp_regfile_mp #(.DATA_W(32), .DEPTH(32), .NUM_RD(2)) dut_a (
    .clk(clk), .rst(rst), .clr_req(clr_req), .busy(busy), .req_drop(req_drop),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid)
`ifdef FP_CLASSIFY_EN
    , .rd_class(rd_class)
`endif
  );

  fp_regfile_mp #(.DATA_W(32), .DEPTH(20), .NUM_RD(2)) dut_b (
    .clk(clk), .rst(rst), .clr_req(b_clr_req), .busy(b_busy), .req_drop(b_req_drop),
    .wr_en(b_wr_en), .wr_addr(b_wr_addr), .wr_data(b_wr_data),
    .rd_en(b_rd_en), .rd_addr(b_rd_addr), .rd_data(b_rd_data), .rd_valid(b_rd_valid)
`ifdef FP_CLASSIFY_EN
    , .rd_class(b_rd_class)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] exp_a(input logic [4:0] addr);
    return (wr_en && wr_addr == addr) ? wr_data : model_a[addr];
  endfunction

  function automatic logic [31:0] exp_b(input logic [4:0] addr);
    if (addr >= 5'd20) return 32'h0;
    return (b_wr_en && b_wr_addr == addr) ? b_wr_data : model_b[addr];
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    total_cnt++; if (busy !== 1'b1) $display("FAIL reset_busy: got %b want 1", busy); else pass_cnt++;
    total_cnt++; if (rd_valid !== 2'b00) $display("FAIL reset_rd_valid: got %b want 00", rd_valid); else pass_cnt++;
    total_cnt++; if (req_drop !== 1'b0) $display("FAIL reset_req_drop: got %b want 0", req_drop); else pass_cnt++;
    total_cnt++; if (rd_data !== 64'h0) $display("FAIL reset_rd_data: got %h want 0", rd_data); else pass_cnt++;
    rst = 1'b0;
    cnt = 0;
    while (busy === 1'b1 && cnt < 200) begin
      cnt++;
      tick();
    end
    total_cnt++; if (cnt != 32) $display("FAIL reset_clear_len: got %0d want 32", cnt); else pass_cnt++;
    for (int i = 0; i < 32; i++) model_a[i] = 32'h0;
    for (int i = 0; i < 20; i++) model_b[i] = 32'h0;
    for (int a = 0; a < 32; a++) begin
      rd_en = 2'b11;
      rd_addr = {5'(31 - a), 5'(a)};
      q0.push_back(exp_a(5'(a)));
      q1.push_back(exp_a(5'(31 - a)));
      tick();
      total_cnt++; if (rd_valid !== 2'b11) $display("FAIL clear_rd_valid[%0d]: got %b want 11", a, rd_valid); else pass_cnt++;
      if (rd_valid[0]) begin
        want = q0.pop_front();
        total_cnt++; if (rd_data[31:0] !== want) $display("FAIL clear_rd0[%0d]: got %h want %h", a, rd_data[31:0], want); else pass_cnt++;
      end
      if (rd_valid[1]) begin
        want = q1.pop_front();
        total_cnt++; if (rd_data[63:32] !== want) $display("FAIL clear_rd1[%0d]: got %h want %h", a, rd_data[63:32], want); else pass_cnt++;
      end
`ifdef FP_CLASSIFY_EN
      total_cnt++; if (rd_class !== 8'b0010_0010) $display("FAIL clear_class[%0d]: got %b want 00100010", a, rd_class); else pass_cnt++;
`endif
    end
    rd_en = 2'b00;
    tick();
    total_cnt++; if (rd_valid !== 2'b00) $display("FAIL valid_pulse: got %b want 00", rd_valid); else pass_cnt++;
    q0.delete();
    q1.delete();
  endtask

  task automatic test_write_read();
    wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'h3F800000;
    tick();
    model_a[5] = 32'h3F800000;
    wr_en = 1'b0;
    rd_en = 2'b01; rd_addr = {5'd0, 5'd5};
    q0.push_back(exp_a(5'd5));
    tick();
    rd_en = 2'b00;
    total_cnt++; if (rd_valid !== 2'b01) $display("FAIL wr_rd_valid: got %b want 01", rd_valid); else pass_cnt++;
    if (rd_valid[0]) begin
      want = q0.pop_front();
      total_cnt++; if (rd_data[31:0] !== want) $display("FAIL wr_rd_data: got %h want %h", rd_data[31:0], want); else pass_cnt++;
    end
`ifdef FP_CLASSIFY_EN
    total_cnt++; if (rd_class[3:0] !== 4'b0000) $display("FAIL wr_rd_class: got %b want 0000", rd_class[3:0]); else pass_cnt++;
`endif
    tick();
    total_cnt++; if (rd_valid !== 2'b00) $display("FAIL hold_valid: got %b want 00", rd_valid); else pass_cnt++;
    total_cnt++; if (rd_data[31:0] !== 32'h3F800000) $display("FAIL hold_data: got %h want 3f800000", rd_data[31:0]); else pass_cnt++;
    q0.delete();
  endtask

  task automatic test_bypass();
    wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'h7F800000;
    rd_en = 2'b11; rd_addr = {5'd9, 5'd9};
    q0.push_back(exp_a(5'd9));
    q1.push_back(exp_a(5'd9));
    tick();
    model_a[9] = 32'h7F800000;
    wr_en = 1'b0; rd_en = 2'b00;
    total_cnt++; if (rd_valid !== 2'b11) $display("FAIL byp_valid: got %b want 11", rd_valid); else pass_cnt++;
    want = q0.pop_front();
    total_cnt++; if (rd_data[31:0] !== want) $display("FAIL byp_rd0: got %h want %h", rd_data[31:0], want); else pass_cnt++;
    want = q1.pop_front();
    total_cnt++; if (rd_data[63:32] !== want) $display("FAIL byp_rd1: got %h want %h", rd_data[63:32], want); else pass_cnt++;
`ifdef FP_CLASSIFY_EN
    total_cnt++; if (rd_class !== 8'b0100_0100) $display("FAIL byp_class: got %b want 01000100", rd_class); else pass_cnt++;
`endif
  endtask

  task automatic test_back_to_back();
    logic [4:0] a0, a1;
    for (int n = 0; n < 48; n++) begin
      wr_en   = 1'($urandom_range(0, 1));
      wr_addr = 5'($urandom_range(0, 31));
      wr_data = $urandom;
      rd_en   = 2'($urandom_range(0, 3));
      a0 = (n % 3 == 0) ? wr_addr : 5'($urandom_range(0, 31));
      a1 = (n % 4 == 0) ? wr_addr : 5'($urandom_range(0, 31));
      rd_addr = {a1, a0};
      exp_v = rd_en;
      if (rd_en[0]) q0.push_back(exp_a(a0));
      if (rd_en[1]) q1.push_back(exp_a(a1));
      tick();
      if (wr_en) model_a[wr_addr] = wr_data;
      total_cnt++; if (rd_valid !== exp_v) $display("FAIL b2b_valid[%0d]: got %b want %b", n, rd_valid, exp_v); else pass_cnt++;
      if (rd_valid[0] && q0.size() > 0) begin
        want = q0.pop_front();
        total_cnt++; if (rd_data[31:0] !== want) $display("FAIL b2b_rd0[%0d]: got %h want %h", n, rd_data[31:0], want); else pass_cnt++;
      end
      if (rd_valid[1] && q1.size() > 0) begin
        want = q1.pop_front();
        total_cnt++; if (rd_data[63:32] !== want) $display("FAIL b2b_rd1[%0d]: got %h want %h", n, rd_data[63:32], want); else pass_cnt++;
      end
    end
    wr_en = 1'b0; rd_en = 2'b00;
    q0.delete();
    q1.delete();
  endtask

  task automatic test_drop_during_clear();
    wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'h12345678;
    tick();
    model_a[3] = 32'h12345678;
    wr_en = 1'b0;
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    total_cnt++; if (busy !== 1'b1) $display("FAIL drop_busy: got %b want 1", busy); else pass_cnt++;
    wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'hDEADBEEF;
    tick();
    wr_en = 1'b0;
    total_cnt++; if (req_drop !== 1'b1) $display("FAIL drop_wr: got %b want 1", req_drop); else pass_cnt++;
    rd_en = 2'b01; rd_addr = {5'd0, 5'd3};
    tick();
    rd_en = 2'b00;
    total_cnt++; if (req_drop !== 1'b1) $display("FAIL drop_rd: got %b want 1", req_drop); else pass_cnt++;
    total_cnt++; if (rd_valid !== 2'b00) $display("FAIL drop_rd_valid: got %b want 00", rd_valid); else pass_cnt++;
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    total_cnt++; if (req_drop !== 1'b0) $display("FAIL drop_idle: got %b want 0", req_drop); else pass_cnt++;
    cnt = 3;
    while (busy === 1'b1 && cnt < 200) begin
      cnt++;
      tick();
    end
    total_cnt++; if (cnt != 32) $display("FAIL clr_req_len: got %0d want 32", cnt); else pass_cnt++;
    for (int i = 0; i < 32; i++) model_a[i] = 32'h0;
    rd_en = 2'b11; rd_addr = {5'd5, 5'd3};
    q0.push_back(exp_a(5'd3));
    q1.push_back(exp_a(5'd5));
    tick();
    rd_en = 2'b00;
    total_cnt++; if (rd_valid !== 2'b11) $display("FAIL drop_after_valid: got %b want 11", rd_valid); else pass_cnt++;
    want = q0.pop_front();
    total_cnt++; if (rd_data[31:0] !== want) $display("FAIL drop_after_rd3: got %h want %h", rd_data[31:0], want); else pass_cnt++;
    want = q1.pop_front();
    total_cnt++; if (rd_data[63:32] !== want) $display("FAIL drop_after_rd5: got %h want %h", rd_data[63:32], want); else pass_cnt++;
  endtask

  task automatic test_reset_mid_clear();
    wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'hCAFEBABE;
    tick();
    wr_addr = 5'd20; wr_data = 32'h11223344;
    tick();
    wr_en = 1'b0;
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    repeat (10) tick();
    rst = 1'b1;
    tick();
    total_cnt++; if (busy !== 1'b1) $display("FAIL midrst_busy: got %b want 1", busy); else pass_cnt++;
    rst = 1'b0;
    cnt = 0;
    while (busy === 1'b1 && cnt < 200) begin
      cnt++;
      tick();
    end
    total_cnt++; if (cnt != 32) $display("FAIL midrst_clear_len: got %0d want 32", cnt); else pass_cnt++;
    for (int i = 0; i < 32; i++) model_a[i] = 32'h0;
    for (int i = 0; i < 20; i++) model_b[i] = 32'h0;
    rd_en = 2'b11; rd_addr = {5'd20, 5'd7};
    q0.push_back(exp_a(5'd7));
    q1.push_back(exp_a(5'd20));
    tick();
    rd_en = 2'b00;
    want = q0.pop_front();
    total_cnt++; if (rd_data[31:0] !== want) $display("FAIL midrst_rd7: got %h want %h", rd_data[31:0], want); else pass_cnt++;
    want = q1.pop_front();
    total_cnt++; if (rd_data[63:32] !== want) $display("FAIL midrst_rd20: got %h want %h", rd_data[63:32], want); else pass_cnt++;
  endtask

  task automatic test_depth20();
    cnt = 0;
    while (b_busy === 1'b1 && cnt < 200) begin
      cnt++;
      tick();
    end
    total_cnt++; if (b_busy !== 1'b0) $display("FAIL d20_busy: got %b want 0", b_busy); else pass_cnt++;
    for (int a = 0; a < 20; a++) begin
      b_wr_en = 1'b1; b_wr_addr = 5'(a); b_wr_data = 32'hB000_0000 + 32'(a * 3);
      tick();
      model_b[a] = b_wr_data;
    end
    b_wr_addr = 5'd25; b_wr_data = 32'hFFFFFFFF;
    tick();
    b_wr_en = 1'b0;
    b_rd_en = 2'b11; b_rd_addr = {5'd19, 5'd25};
    q0.push_back(exp_b(5'd25));
    q1.push_back(exp_b(5'd19));
    tick();
    b_rd_en = 2'b00;
    total_cnt++; if (b_rd_valid !== 2'b11) $display("FAIL d20_oob_valid: got %b want 11", b_rd_valid); else pass_cnt++;
    want = q0.pop_front();
    total_cnt++; if (b_rd_data[31:0] !== want) $display("FAIL d20_oob_rd: got %h want %h", b_rd_data[31:0], want); else pass_cnt++;
    want = q1.pop_front();
    total_cnt++; if (b_rd_data[63:32] !== want) $display("FAIL d20_rd19: got %h want %h", b_rd_data[63:32], want); else pass_cnt++;
    b_wr_en = 1'b1; b_wr_addr = 5'd25; b_wr_data = 32'h5A5A5A5A;
    b_rd_en = 2'b11; b_rd_addr = {5'd25, 5'd25};
    q0.push_back(exp_b(5'd25));
    q1.push_back(exp_b(5'd25));
    tick();
    b_wr_en = 1'b0; b_rd_en = 2'b00;
    want = q0.pop_front();
    total_cnt++; if (b_rd_data[31:0] !== want) $display("FAIL d20_oob_byp0: got %h want %h", b_rd_data[31:0], want); else pass_cnt++;
    want = q1.pop_front();
    total_cnt++; if (b_rd_data[63:32] !== want) $display("FAIL d20_oob_byp1: got %h want %h", b_rd_data[63:32], want); else pass_cnt++;
    for (int a = 0; a < 20; a++) begin
      b_rd_en = 2'b11; b_rd_addr = {5'(19 - a), 5'(a)};
      q0.push_back(exp_b(5'(a)));
      q1.push_back(exp_b(5'(19 - a)));
      tick();
      if (b_rd_valid[0]) begin
        got = b_rd_data[31:0];
        want = q0.pop_front();
        total_cnt++; if (got !== want) $display("FAIL d20_keep0[%0d]: got %h want %h", a, got, want); else pass_cnt++;
      end else begin
        total_cnt++; $display("FAIL d20_keep_valid[%0d]: got %b want 11", a, b_rd_valid);
        void'(q0.pop_front());
      end
      if (b_rd_valid[1]) begin
        got = b_rd_data[63:32];
        want = q1.pop_front();
        total_cnt++; if (got !== want) $display("FAIL d20_keep1[%0d]: got %h want %h", a, got, want); else pass_cnt++;
      end else begin
        void'(q1.pop_front());
      end
    end
    b_rd_en = 2'b00;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; clr_req = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0; rd_en = '0; rd_addr = '0;
    b_clr_req = 1'b0; b_wr_en = 1'b0; b_wr_addr = '0; b_wr_data = '0; b_rd_en = '0; b_rd_addr = '0;
    test_reset();
    test_write_read();
    test_bypass();
    test_back_to_back();
    test_drop_during_clear();
    test_reset_mid_clear();
    test_depth20();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
